spatial_mean_scheduler: RTL and testbench
=========================================

Name: spatial_mean_scheduler

Overview:
Sequencer that drives one channel-wise mean datapath across a full feature map for the spatial gate. For each pixel it reads the IN_CH channel values of that pixel from a channel-major feature buffer, streams them into the mean unit, and captures the mean. It then writes the mean into a single-channel spatial map buffer. Software or an upstream FSM issues i_start, and the block reports completion with o_done and a sticky o_err.

Parameters:
DATA_W, 8, signed sample width (feature and mean).
IN_CH, 8, channels per pixel (power of two, >=2).
IMG_H, 4, feature map height.
IMG_W, 4, feature map width.
TIMEOUT, 16, max cycles spent in WAIT_MEAN before error.
RD_ADDR_W, $clog2(IN_CH*IMG_H*IMG_W), feature buffer address width (localparam).
WR_ADDR_W, $clog2(IMG_H*IMG_W), spatial map address width (localparam).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start request; sampled only in IDLE
o_busy  out  1  high from the cycle after accepted start until o_done cycle inclusive
o_done  out  1  one-cycle pulse at end of frame
o_err  out  1  sticky timeout flag; cleared on next accepted start
o_rd_en  out  1  feature buffer read strobe (registered)
o_rd_addr  out  RD_ADDR_W  read address = ch*IMG_H*IMG_W + pix (registered)
i_rd_data  in  DATA_W  signed read data, valid exactly 1 cycle after o_rd_en
o_mean_valid  out  1  to mean unit i_valid; o_rd_en delayed 1 cycle
o_mean_data  out  DATA_W  to mean unit i_data; i_rd_data passed through
i_mean_valid  in  1  from mean unit o_valid
i_mean_data  in  DATA_W  from mean unit o_data
o_wr_en  out  1  spatial map write strobe (registered, one cycle)
o_wr_addr  out  WR_ADDR_W  pixel index pix = row*IMG_W + col
o_wr_data  out  DATA_W  captured mean

Behaviour:
- Clock/reset: one clock clk; asynchronous active-low reset rst_n.
- Reset: state IDLE, counters 0, and every output 0: o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_mean_valid, o_wr_en, o_wr_addr, o_wr_data. o_mean_data follows i_rd_data.
- Reset mid-frame: abort immediately with no further reads or writes. The mean unit is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT_MEAN, DONE.
- IDLE:
  - On i_start: clear o_err, pix=0, ch=0, go to ISSUE.
  - The first o_rd_en (addr 0) is asserted in the cycle after i_start is sampled.
- ISSUE:
  - Asserts o_rd_en on IN_CH consecutive cycles, ch = 0..IN_CH-1, for the current pix.
  - On ch==IN_CH-1: go to WAIT_MEAN and clear the timeout counter.
  - No bubbles inside a pixel burst. This is mandatory: the mean unit counts inputs and needs exactly IN_CH valids per pixel.
- Data path to mean unit:
  - o_mean_valid = o_rd_en delayed 1 cycle.
  - o_mean_data = i_rd_data (combinational).
- WAIT_MEAN:
  - The timeout counter increments each cycle.
  - On i_mean_valid: register o_wr_en=1, o_wr_addr=pix, o_wr_data=i_mean_data.
    - If pix==IMG_H*IMG_W-1: go to DONE.
    - Else: pix++, ch=0, go to ISSUE.
  - The next pixel's first read therefore coincides with the previous write strobe.
  - No new read is issued before i_mean_valid, because the mean unit cannot accept data in its output cycle.
  - With a nominal mean unit, i_mean_valid arrives 3 cycles after the last o_rd_en of a burst.
  - Timeout: if the counter reaches TIMEOUT without i_mean_valid, set o_err, perform no write, go to DONE.
- DONE:
  - o_done=1 for one cycle, o_busy still 1, then IDLE.
- i_start while busy (ISSUE, WAIT_MEAN or DONE) is ignored, not queued.
- i_mean_valid outside WAIT_MEAN is ignored (no write).
- Arithmetic:
  - Address math is unsigned, with the product IMG_H*IMG_W as a constant.
  - pix and ch wrap only through the state transitions, never by overflow.
  - Data is not modified by this block.

Test Plan:
1. Nominal frame (IN_CH=4, IMG_H=IMG_W=2, all 16 channels written as pix*10+ch, real mean unit attached): pulse i_start.
   - Read addresses follow 0,4,8,12 | 1,5,9,13 | 2,6,10,14 | 3,7,11,15.
   - Writes go to addr 0..3 with data 1,11,21,31.
   - o_done pulses once, one cycle after the write to addr 3; o_err=0.
2. Negative data (all channels of pix 0 = -3, pix 1 = -8): writes -3 (mean of 4×-3 = -12>>>2) and -8, showing signed passthrough.
3. Timeout (stub mean unit never asserts valid at pix 2, TIMEOUT=16):
   - No write to addr 2.
   - o_err=1 and o_done pulses 16 cycles after the pix 2 burst.
   - o_err stays 1 until the next i_start, then clears.
4. i_start re-pulsed during ISSUE and during WAIT_MEAN: no effect; read sequence and write count (4) are unchanged, and o_done pulses exactly once.
5. Reset asserted while in ISSUE at pix 1, ch 2: all outputs 0 immediately. After release, i_start runs a clean full frame from addr 0.
6. Spurious i_mean_valid injected during ISSUE: no o_wr_en, and the frame results are identical to scenario 1.

Source files
------------

// File: rtl/spatial_mean_scheduler.sv
// rtl/spatial_mean_scheduler.sv - sequences per-pixel channel reads through a mean unit into a spatial map
// Reads all channels of one pixel back-to-back, waits for the mean, writes it, repeats for the frame.
module spatial_mean_scheduler #(
    parameter  int DATA_W    = 8,
    parameter  int IN_CH     = 8,
    parameter  int IMG_H     = 4,
    parameter  int IMG_W     = 4,
    parameter  int TIMEOUT   = 16,
    localparam int NPIX      = IMG_H * IMG_W,
    localparam int RD_ADDR_W = $clog2(IN_CH * NPIX),
    localparam int WR_ADDR_W = $clog2(NPIX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_rd_en,
    output logic [RD_ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0]    i_rd_data,
    output logic                 o_mean_valid,
    output logic [DATA_W-1:0]    o_mean_data,
    input  logic                 i_mean_valid,
    input  logic [DATA_W-1:0]    i_mean_data,
    output logic                 o_wr_en,
    output logic [WR_ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0]    o_wr_data
);

    localparam int CH_W  = $clog2(IN_CH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MEAN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [WR_ADDR_W-1:0]   pix_q, pix_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   rd_en_q, rd_en_d;
    logic [RD_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                   mean_valid_q;
    logic                   wr_en_q, wr_en_d;
    logic [WR_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    function automatic logic [RD_ADDR_W-1:0] feat_addr(input logic [CH_W-1:0] ch,
                                                      input logic [WR_ADDR_W-1:0] pix);
        feat_addr = RD_ADDR_W'(RD_ADDR_W'(ch) * RD_ADDR_W'(NPIX)) + RD_ADDR_W'(pix);
    endfunction

    // ch_q holds the next channel to issue; channel 0 of each pixel is issued on the entry edge.
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        ch_d      = ch_q;
        tmo_d     = tmo_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        done_d    = (state_q == S_DONE);
        busy_d    = done_q ? 1'b0 : busy_q;

        case (state_q)
            S_IDLE: begin
                // busy_q still high here means the o_done cycle, which counts as busy.
                if (i_start && !busy_q) begin
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    pix_d     = '0;
                    ch_d      = CH_W'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_en_d   = 1'b1;
                rd_addr_d = feat_addr(ch_q, pix_q);
                if (ch_q == CH_W'(IN_CH - 1)) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_MEAN;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            S_WAIT_MEAN: begin
                tmo_d = tmo_q + 1'b1;
                if (i_mean_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_q;
                    wr_data_d = i_mean_data;
                    if (pix_q == WR_ADDR_W'(NPIX - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        pix_d     = pix_q + 1'b1;
                        ch_d      = CH_W'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = feat_addr('0, pix_q + 1'b1);
                        state_d   = S_ISSUE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pix_q        <= '0;
            ch_q         <= '0;
            tmo_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            mean_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            ch_q         <= ch_d;
            tmo_q        <= tmo_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            mean_valid_q <= rd_en_q;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_rd_en      = rd_en_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_mean_valid = mean_valid_q;
    assign o_mean_data  = i_rd_data;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_spatial_mean_scheduler.sv
// tb/tb_spatial_mean_scheduler.sv - self-checking bench for spatial_mean_scheduler
// Behavioural feature buffer and mean unit around the DUT; expectations come from loop arithmetic.
module tb_spatial_mean_scheduler;

    localparam int DW   = 8;
    localparam int NC   = 4;
    localparam int H    = 2;
    localparam int W    = 2;
    localparam int TMO  = 16;
    localparam int NPIX = H * W;
    localparam int RAW  = $clog2(NC * NPIX);
    localparam int WAW  = $clog2(NPIX);
    localparam int LOG2 = $clog2(NC);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic           o_busy, o_done, o_err, o_rd_en, o_mean_valid, o_wr_en;
    logic [RAW-1:0] o_rd_addr;
    logic [WAW-1:0] o_wr_addr;
    logic [DW-1:0]  i_rd_data = '0;
    logic [DW-1:0]  o_mean_data, o_wr_data, i_mean_data;
    logic           i_mean_valid;

    always #5 clk = ~clk;

    spatial_mean_scheduler #(
        .DATA_W(DW), .IN_CH(NC), .IMG_H(H), .IMG_W(W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_mean_valid(o_mean_valid), .o_mean_data(o_mean_data),
        .i_mean_valid(i_mean_valid), .i_mean_data(i_mean_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
    );

    logic signed [DW-1:0] mem [NC*NPIX];
    int  ncmp = 0;
    int  nerr = 0;
    int  cyc = 0;
    int  stall = -1;
    logic spur = 1'b0;
    logic clr_mon = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Feature buffer: data valid one cycle after the read strobe.
    always @(posedge clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

    // Mean unit: accumulates NC inputs, answers 2 cycles after its last input; can be told to stay silent.
    int   acc, cnt, burst, tsum;
    logic p1, outv;
    logic [DW-1:0] p1d, outd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 0; cnt <= 0; burst <= 0; p1 <= 1'b0; outv <= 1'b0; p1d <= '0; outd <= '0;
        end else if (clr_mon) begin
            acc <= 0; cnt <= 0; burst <= 0; p1 <= 1'b0; outv <= 1'b0;
        end else begin
            p1   <= 1'b0;
            outv <= 1'b0;
            if (o_mean_valid) begin
                tsum = acc + int'($signed(o_mean_data));
                if (cnt == NC - 1) begin
                    p1    <= (burst != stall);
                    p1d   <= DW'(tsum >>> LOG2);
                    acc   <= 0;
                    cnt   <= 0;
                    burst <= burst + 1;
                end else begin
                    acc <= tsum;
                    cnt <= cnt + 1;
                end
            end
            if (p1) begin
                outv <= 1'b1;
                outd <= p1d;
            end
        end
    end
    assign i_mean_valid = outv | spur;
    assign i_mean_data  = spur ? 8'h55 : outd;

    int rd_a[$], rd_c[$], wr_a[$], wr_d[$], wr_c[$];
    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (clr_mon) begin
            rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
            done_cnt = 0;
        end else if (rst_n) begin
            if (o_rd_en) begin rd_a.push_back(int'(o_rd_addr)); rd_c.push_back(cyc); end
            if (o_wr_en) begin
                wr_a.push_back(int'(o_wr_addr));
                wr_d.push_back(int'($signed(o_wr_data)));
                wr_c.push_back(cyc);
            end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        step();
        clr_mon = 1'b0;
    endtask

    function automatic int ref_mean(input int p);
        int s = 0;
        int q;
        for (int c = 0; c < NC; c++) s += int'(mem[c*NPIX + p]);
        q = s / NC;
        if ((s % NC) != 0 && s < 0) q -= 1;
        return q;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk(tag, 32'({o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_mean_valid,
                      o_wr_en, o_wr_addr, o_wr_data}), 0);
        chk({tag, "_mean_data"}, 32'(o_mean_data), 32'(i_rd_data));
    endtask

    task automatic run_frame(input int stall_p, input bit mid_start, input bit spur_en, input logic exp_err);
        int  st_cyc, npr, nw, last;
        bit  s1 = 0, s2 = 0, sp = 0;
        stall = stall_p;
        clear_mon();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        st_cyc  = cyc;
        chk("busy_after_start", o_busy, 1);
        chk("err_cleared_on_start", o_err, 0);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            i_start = 1'b0;
            spur    = 1'b0;
            if (mid_start && !s1 && o_rd_en && o_rd_addr == RAW'(NPIX + 1)) begin
                i_start = 1'b1; s1 = 1;
            end
            if (mid_start && !s2 && rd_a.size() == 2*NC && !o_rd_en) begin
                i_start = 1'b1; s2 = 1;
            end
            if (spur_en && !sp && o_rd_en && o_rd_addr == RAW'(NPIX)) begin
                spur = 1'b1; sp = 1;
            end
            step();
        end
        spur    = 1'b0;
        i_start = mid_start;
        chk("done_seen", done_cnt, 1);
        chk("err_flag", o_err, exp_err);
        step();
        i_start = 1'b0;
        chk("busy_after_done", o_busy, 0);
        for (int k = 0; k < 6; k++) step();
        chk("done_once", done_cnt, 1);

        npr = (stall_p < 0) ? NPIX : stall_p + 1;
        nw  = (stall_p < 0) ? NPIX : stall_p;
        chk("rd_count", rd_a.size(), npr*NC);
        if (rd_c.size() > 0) chk("first_rd_latency", rd_c[0], st_cyc);
        for (int p = 0; p < npr; p++)
            for (int c = 0; c < NC; c++)
                if (p*NC + c < rd_a.size()) begin
                    chk($sformatf("rd_addr_p%0d_c%0d", p, c), rd_a[p*NC+c], c*NPIX + p);
                    chk($sformatf("rd_nobubble_p%0d_c%0d", p, c), rd_c[p*NC+c] - rd_c[p*NC], c);
                end
        chk("wr_count", wr_a.size(), nw);
        for (int p = 0; p < nw && p < wr_a.size(); p++) begin
            chk($sformatf("wr_addr_%0d", p), wr_a[p], p);
            chk($sformatf("wr_data_%0d", p), wr_d[p], ref_mean(p));
            if ((p+1)*NC < rd_c.size())
                chk($sformatf("next_rd_with_wr_%0d", p), rd_c[(p+1)*NC], wr_c[p]);
        end
        if (stall_p < 0 && wr_c.size() > 0)
            chk("done_after_last_wr", done_cyc - wr_c[wr_c.size()-1], 1);
        if (stall_p >= 0 && rd_c.size() > 0) begin
            last = rd_c[rd_c.size()-1];
            chk("timeout_done_delay", done_cyc - last, TMO + 1);
        end
    endtask

    task automatic fill_pattern();
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < NC; c++) mem[c*NPIX + p] = DW'(p*10 + c);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NC*NPIX; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        fill_pattern();
        rst_n = 1'b0;
        step();
        check_zero_outputs("reset_state");
        step();
        rst_n = 1'b1;
        step();

        // Nominal frame with known pattern: means 1, 11, 21, 31.
        run_frame(-1, 0, 0, 1'b0);
        chk("pattern_mean_pix3", ref_mean(3), 31);

        // Negative data shows signed passthrough.
        fill_random();
        for (int c = 0; c < NC; c++) begin mem[c*NPIX] = -8'sd3; mem[c*NPIX + 1] = -8'sd8; end
        run_frame(-1, 0, 0, 1'b0);
        if (wr_d.size() > 1) begin
            chk("neg_mean_pix0", wr_d[0], -3);
            chk("neg_mean_pix1", wr_d[1], -8);
        end

        // Mean unit silent at pixel 2: timeout, error sticks until next start.
        fill_random();
        run_frame(2, 0, 0, 1'b1);
        for (int k = 0; k < 5; k++) step();
        chk("err_sticky", o_err, 1);

        // Start pulses during ISSUE, WAIT_MEAN and the done cycle are ignored.
        fill_random();
        run_frame(-1, 1, 0, 1'b0);

        // Reset in the middle of pixel 1's burst.
        fill_random();
        stall = -1;
        clear_mon();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 100 && !(o_rd_en && o_rd_addr == RAW'(2*NPIX + 1)); k++) step();
        chk("reached_pix1_ch2", 32'(o_rd_addr), 2*NPIX + 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_midframe");
        step();
        step();
        rst_n = 1'b1;
        clear_mon();
        for (int k = 0; k < 8; k++) step();
        chk("idle_after_reset_reads", rd_a.size() + wr_a.size() + done_cnt, 0);
        run_frame(-1, 0, 0, 1'b0);

        // Spurious mean-valid while issuing must not write anything.
        fill_pattern();
        run_frame(-1, 0, 1, 1'b0);

        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(-1, 0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
